// File: rtl/issue_ready_array_pkg.sv
// Shared issue-queue types: sizing constants, the entry record
// and the dispatch-lane payload used by the ready array.
package issue_ready_array_pkg;

    localparam int IQ_SIZE        = 32;
    localparam int DISPATCH_WIDTH = 4;
    localparam int WAKEUP_WIDTH   = 4;
    localparam int TAG_BITS       = 7;
    localparam int IDX_BITS       = $clog2(IQ_SIZE);
    localparam int CNT_BITS       = IDX_BITS + 1;
    localparam int LANE_BITS      = $clog2(DISPATCH_WIDTH);

    typedef logic [TAG_BITS-1:0] tag_t;
    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [CNT_BITS-1:0] cnt_t;

    typedef struct packed {
        logic            valid;
        logic [1:0]      rdy;
        tag_t [1:0]      tag;
    } iq_entry_t;

    typedef struct packed {
        logic            valid;
        idx_t            idx;
        tag_t [1:0]      tag;
        logic [1:0]      rdy;
    } disp_lane_t;

    function automatic cnt_t popcount(input logic [IQ_SIZE-1:0] v);
        cnt_t n;
        n = '0;
        for (int i = 0; i < IQ_SIZE; i++)
            n = n + cnt_t'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/issue_ready_array_wakeup_tag_match.sv
// Compares one source tag against every wakeup broadcast port.
// Asserts hit when any valid port carries the same tag.
module wakeup_tag_match
    import issue_ready_array_pkg::*;
(
    input  logic [TAG_BITS-1:0]                  tag,
    input  logic [WAKEUP_WIDTH-1:0]              wk_valid,
    input  logic [WAKEUP_WIDTH-1:0][TAG_BITS-1:0] wk_tag,
    output logic                                 hit
);

    always_comb begin
        hit = 1'b0;
        for (int w = 0; w < WAKEUP_WIDTH; w++)
            hit = hit | (wk_valid[w] && (wk_tag[w] == tag));
    end

endmodule

// File: rtl/issue_ready_array.sv
// Issue-queue valid/ready state: dispatch, wakeup match, grant retire,
// request vector to the select tree, occupancy count and error flag.
module issue_ready_array
    import issue_ready_array_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      flush_i,
    input  logic [DISPATCH_WIDTH-1:0]                 disp_valid_i,
    input  logic [DISPATCH_WIDTH-1:0][IDX_BITS-1:0]   disp_idx_i,
    input  logic [DISPATCH_WIDTH-1:0][1:0][TAG_BITS-1:0] disp_tag_i,
    input  logic [DISPATCH_WIDTH-1:0][1:0]            disp_rdy_i,
    input  logic [WAKEUP_WIDTH-1:0]                   wk_valid_i,
    input  logic [WAKEUP_WIDTH-1:0][TAG_BITS-1:0]     wk_tag_i,
    input  logic [IQ_SIZE-1:0]                        grant_i,
    output logic [IQ_SIZE-1:0]                        req_o,
    output logic [IQ_SIZE-1:0]                        valid_o,
    output logic [IDX_BITS:0]                         count_o,
    output logic                                      err_o
);

    iq_entry_t  ent_q [IQ_SIZE];
    iq_entry_t  ent_d [IQ_SIZE];

    disp_lane_t [DISPATCH_WIDTH-1:0] lane;
    logic [DISPATCH_WIDTH-1:0][1:0]  lane_hit;
    logic [IQ_SIZE-1:0][1:0]         ent_hit;

    logic [IQ_SIZE-1:0]                disp_hit;
    logic [IQ_SIZE-1:0]                disp_dup;
    logic [IQ_SIZE-1:0][LANE_BITS-1:0] disp_sel;
    logic [IQ_SIZE-1:0]                grant_ok;
    logic [IQ_SIZE-1:0]                alloc;
    logic [IDX_BITS:0]                 count_d;
    logic                              err_d;

    // Lane sources also see this cycle's wakeups (dispatch bypass).
    for (genvar d = 0; d < DISPATCH_WIDTH; d++) begin : g_lane
        for (genvar s = 0; s < 2; s++) begin : g_src
            wakeup_tag_match u_match (
                .tag      (disp_tag_i[d][s]),
                .wk_valid (wk_valid_i),
                .wk_tag   (wk_tag_i),
                .hit      (lane_hit[d][s])
            );
        end
        assign lane[d] = '{
            valid: disp_valid_i[d],
            idx:   disp_idx_i[d],
            tag:   disp_tag_i[d],
            rdy:   disp_rdy_i[d] | lane_hit[d]
        };
    end

    for (genvar i = 0; i < IQ_SIZE; i++) begin : g_ent
        for (genvar s = 0; s < 2; s++) begin : g_src
            wakeup_tag_match u_match (
                .tag      (ent_q[i].tag[s]),
                .wk_valid (wk_valid_i),
                .wk_tag   (wk_tag_i),
                .hit      (ent_hit[i][s])
            );
        end
        assign valid_o[i] = ent_q[i].valid;
        assign req_o[i]   = ent_q[i].valid & (&ent_q[i].rdy);
    end

    // Walk lanes high to low so the lowest lane owns a shared index.
    always_comb begin
        disp_hit = '0;
        disp_dup = '0;
        disp_sel = '0;
        for (int d = DISPATCH_WIDTH - 1; d >= 0; d--) begin
            if (lane[d].valid) begin
                if (disp_hit[lane[d].idx])
                    disp_dup[lane[d].idx] = 1'b1;
                disp_hit[lane[d].idx] = 1'b1;
                disp_sel[lane[d].idx] = LANE_BITS'(d);
            end
        end
    end

    always_comb begin
        grant_ok = grant_i & req_o;
        alloc    = disp_hit & (~valid_o | grant_ok);
        for (int i = 0; i < IQ_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (disp_hit[i]) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].tag   = lane[disp_sel[i]].tag;
                ent_d[i].rdy   = lane[disp_sel[i]].rdy;
            end else if (grant_ok[i]) begin
                ent_d[i].valid = 1'b0;
            end else if (ent_q[i].valid) begin
                ent_d[i].rdy = ent_q[i].rdy | ent_hit[i];
            end
        end
        count_d = count_o + popcount(alloc) - popcount(grant_ok);
        err_d   = err_o
                | (|disp_dup)
                | (|(disp_hit & valid_o & ~grant_ok))
                | (|(grant_i & ~req_o));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IQ_SIZE; i++)
                ent_q[i] <= '0;
            count_o <= '0;
            err_o   <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < IQ_SIZE; i++)
                ent_q[i].valid <= 1'b0;
            count_o <= '0;
        end else begin
            ent_q   <= ent_d;
            count_o <= count_d;
            err_o   <= err_d;
        end
    end

endmodule

// File: tb/tb_issue_ready_array.sv
// Directed and randomized bench for issue_ready_array against a
// behavioural model of entry occupancy, readiness and violations.
module tb_issue_ready_array;
    import issue_ready_array_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush_i;
    logic [DISPATCH_WIDTH-1:0]                    disp_valid_i;
    logic [DISPATCH_WIDTH-1:0][IDX_BITS-1:0]      disp_idx_i;
    logic [DISPATCH_WIDTH-1:0][1:0][TAG_BITS-1:0] disp_tag_i;
    logic [DISPATCH_WIDTH-1:0][1:0]               disp_rdy_i;
    logic [WAKEUP_WIDTH-1:0]                      wk_valid_i;
    logic [WAKEUP_WIDTH-1:0][TAG_BITS-1:0]        wk_tag_i;
    logic [IQ_SIZE-1:0]                           grant_i;
    logic [IQ_SIZE-1:0]                           req_o;
    logic [IQ_SIZE-1:0]                           valid_o;
    logic [IDX_BITS:0]                            count_o;
    logic                                         err_o;

    int checks = 0;
    int errors = 0;

    bit m_valid [IQ_SIZE];
    bit m_rdy   [IQ_SIZE][2];
    int m_tag   [IQ_SIZE][2];
    int m_count;
    bit m_err;

    always #5 clk = ~clk;

    issue_ready_array dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .disp_valid_i (disp_valid_i),
        .disp_idx_i   (disp_idx_i),
        .disp_tag_i   (disp_tag_i),
        .disp_rdy_i   (disp_rdy_i),
        .wk_valid_i   (wk_valid_i),
        .wk_tag_i     (wk_tag_i),
        .grant_i      (grant_i),
        .req_o        (req_o),
        .valid_o      (valid_o),
        .count_o      (count_o),
        .err_o        (err_o)
    );

    task automatic chk(input string name,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit woken(input int t);
        for (int w = 0; w < WAKEUP_WIDTH; w++)
            if (wk_valid_i[w] && int'(wk_tag_i[w]) == t)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_req(input int i);
        return m_valid[i] && m_rdy[i][0] && m_rdy[i][1];
    endfunction

    task automatic idle();
        flush_i      = 1'b0;
        disp_valid_i = '0;
        disp_idx_i   = '0;
        disp_tag_i   = '0;
        disp_rdy_i   = '0;
        wk_valid_i   = '0;
        wk_tag_i     = '0;
        grant_i      = '0;
    endtask

    task automatic disp(input int l, input int idx,
                        input int t0, input int t1,
                        input bit r0, input bit r1);
        disp_valid_i[l]    = 1'b1;
        disp_idx_i[l]      = IDX_BITS'(idx);
        disp_tag_i[l][0]   = TAG_BITS'(t0);
        disp_tag_i[l][1]   = TAG_BITS'(t1);
        disp_rdy_i[l]      = {r1, r0};
    endtask

    task automatic wake(input int p, input int t);
        wk_valid_i[p] = 1'b1;
        wk_tag_i[p]   = TAG_BITS'(t);
    endtask

    task automatic check_all();
        logic [IQ_SIZE-1:0] er;
        logic [IQ_SIZE-1:0] ev;
        for (int i = 0; i < IQ_SIZE; i++) begin
            er[i] = m_req(i);
            ev[i] = m_valid[i];
        end
        chk("req_o", 64'(req_o), 64'(er));
        chk("valid_o", 64'(valid_o), 64'(ev));
        chk("count_o", 64'(count_o), 64'(m_count));
        chk("err_o", 64'(err_o), 64'(m_err));
    endtask

    // Apply current inputs for one cycle, advance the model, then check.
    task automatic step();
        bit nv [IQ_SIZE];
        bit nr [IQ_SIZE][2];
        int nt [IQ_SIZE][2];
        bit taken [IQ_SIZE];
        bit ne;
        nv = m_valid;
        nr = m_rdy;
        nt = m_tag;
        ne = m_err;
        if (reset) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                nv[i] = 0;
                nr[i][0] = 0;
                nr[i][1] = 0;
            end
            ne = 0;
        end else if (flush_i) begin
            for (int i = 0; i < IQ_SIZE; i++)
                nv[i] = 0;
        end else begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                taken[i] = 0;
                if (grant_i[i] && !m_req(i))
                    ne = 1;
                if (m_valid[i])
                    for (int s = 0; s < 2; s++)
                        if (woken(m_tag[i][s]))
                            nr[i][s] = 1;
                if (grant_i[i] && m_req(i))
                    nv[i] = 0;
            end
            for (int d = 0; d < DISPATCH_WIDTH; d++) begin
                if (disp_valid_i[d]) begin
                    int e;
                    e = int'(disp_idx_i[d]);
                    if (taken[e]) begin
                        ne = 1;
                    end else begin
                        taken[e] = 1;
                        if (m_valid[e] && !(grant_i[e] && m_req(e)))
                            ne = 1;
                        nv[e] = 1;
                        for (int s = 0; s < 2; s++) begin
                            nt[e][s] = int'(disp_tag_i[d][s]);
                            nr[e][s] = disp_rdy_i[d][s] || woken(nt[e][s]);
                        end
                    end
                end
            end
        end
        @(posedge clk);
        m_valid = nv;
        m_rdy   = nr;
        m_tag   = nt;
        m_err   = ne;
        m_count = 0;
        foreach (nv[i])
            m_count += int'(nv[i]);
        #1;
        check_all();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_valid", 64'(valid_o), 64'd0);

        // Ready-at-rename dispatch
        disp(0, 5, 10, 11, 1, 1);
        step();
        chk("t1_req5", 64'(req_o[5]), 64'd1);
        chk("t1_count", 64'(count_o), 64'd1);

        // Two staggered wakeups
        disp(0, 3, 20, 21, 0, 0);
        step();
        step();
        wake(0, 20);
        step();
        chk("t2_req3_half", 64'(req_o[3]), 64'd0);
        step();
        wake(2, 21);
        step();
        chk("t2_req3_full", 64'(req_o[3]), 64'd1);

        // Same-cycle bypass and a tag absent from the array
        disp(0, 7, 30, 99, 0, 1);
        wake(0, 30);
        wake(1, 77);
        step();
        chk("t3_req7_bypass", 64'(req_o[7]), 64'd1);

        // Grant and re-dispatch of the same entry
        grant_i[5] = 1'b1;
        disp(0, 5, 40, 41, 0, 0);
        step();
        chk("t4_valid5", 64'(valid_o[5]), 64'd1);
        chk("t4_req5", 64'(req_o[5]), 64'd0);
        chk("t4_count", 64'(count_o), 64'd3);
        chk("t4_err", 64'(err_o), 64'd0);

        // Fill every entry ready, then flush with concurrent traffic
        wake(0, 40);
        wake(1, 41);
        step();
        begin
            int l;
            l = 0;
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (!m_valid[i]) begin
                    disp(l, i, i, i + 1, 1, 1);
                    l++;
                    if (l == DISPATCH_WIDTH) begin
                        step();
                        l = 0;
                    end
                end
            end
            if (l != 0)
                step();
        end
        chk("t5_full_count", 64'(count_o), 64'(IQ_SIZE));
        chk("t5_full_req", 64'(req_o), 64'(32'hffff_ffff));
        flush_i = 1'b1;
        grant_i = '1;
        disp(0, 0, 1, 2, 1, 1);
        wake(0, 3);
        step();
        chk("t5_flush_req", 64'(req_o), 64'd0);
        chk("t5_flush_count", 64'(count_o), 64'd0);

        // Randomized protocol-clean traffic
        for (int c = 0; c < 400; c++) begin
            bit used [IQ_SIZE];
            foreach (used[i])
                used[i] = 0;
            if ($urandom_range(49) == 0)
                flush_i = 1'b1;
            for (int i = 0; i < IQ_SIZE; i++)
                if (m_req(i) && $urandom_range(2) == 0)
                    grant_i[i] = 1'b1;
            for (int d = 0; d < DISPATCH_WIDTH; d++) begin
                if ($urandom_range(1) == 1) begin
                    for (int k = 0; k < 8; k++) begin
                        int e;
                        e = int'($urandom_range(IQ_SIZE - 1));
                        if (!used[e] && (!m_valid[e] || grant_i[e])) begin
                            used[e] = 1;
                            disp(d, e, int'($urandom_range(15)),
                                 int'($urandom_range(15)),
                                 1'($urandom_range(1)),
                                 1'($urandom_range(1)));
                            break;
                        end
                    end
                end
            end
            for (int w = 0; w < WAKEUP_WIDTH; w++)
                if ($urandom_range(1) == 1)
                    wake(w, int'($urandom_range(15)));
            step();
        end

        // Duplicate index: lane 0 payload kept, error sticky
        do_reset();
        disp(0, 9, 50, 51, 0, 0);
        disp(1, 9, 60, 61, 1, 1);
        step();
        chk("t6_req9_lane0", 64'(req_o[9]), 64'd0);
        chk("t6_err", 64'(err_o), 64'd1);
        wake(0, 50);
        wake(1, 51);
        step();
        chk("t6_req9_woken", 64'(req_o[9]), 64'd1);
        step();
        step();
        chk("t6_err_sticky", 64'(err_o), 64'd1);
        do_reset();
        chk("t6_err_cleared", 64'(err_o), 64'd0);

        // Grant without request is ignored but flagged
        disp(0, 2, 5, 6, 0, 0);
        step();
        grant_i[2] = 1'b1;
        step();
        chk("t7_valid2", 64'(valid_o[2]), 64'd1);
        chk("t7_err", 64'(err_o), 64'd1);
        do_reset();

        // Dispatch over a live entry overwrites and flags
        disp(0, 4, 1, 2, 0, 0);
        step();
        disp(0, 4, 3, 4, 1, 1);
        step();
        chk("t8_req4", 64'(req_o[4]), 64'd1);
        chk("t8_count", 64'(count_o), 64'd1);
        chk("t8_err", 64'(err_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_ready_array.md
# issue_ready_array

Per-entry valid and source-operand ready state for the issue queue; the stage directly upstream of the select tree. Records dispatched entries, matches wakeup-tag broadcasts against pending source tags, and drives the request vector that the select blocks arbitrate. Consumes the final per-entry grant from the select tree to retire issued entries.

## Interface
- IQ_SIZE, 32: issue-queue entries; power of two.
- DISPATCH_WIDTH, 4: dispatch lanes per cycle.
- WAKEUP_WIDTH, 4: wakeup tag broadcast ports.
- TAG_BITS, 7: physical register tag width.
- IDX_BITS, $clog2(IQ_SIZE).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush_i  in  1  pipeline flush; invalidates every entry.
- disp_valid_i  in  DISPATCH_WIDTH  per-lane dispatch strobe.
- disp_idx_i  in  DISPATCH_WIDTH x IDX_BITS  target entry per lane.
- disp_tag_i  in  DISPATCH_WIDTH x 2 x TAG_BITS  source tags (src0, src1).
- disp_rdy_i  in  DISPATCH_WIDTH x 2  source already ready at rename.
- wk_valid_i  in  WAKEUP_WIDTH  wakeup strobe per port.
- wk_tag_i  in  WAKEUP_WIDTH x TAG_BITS  produced tag per port.
- grant_i  in  IQ_SIZE  OR of all issue lanes' one-hot grants from the select tree.
- req_o  out  IQ_SIZE  valid & src0_rdy & src1_rdy per entry.
- valid_o  out  IQ_SIZE  entry occupancy, to the free list.
- count_o  out  IDX_BITS+1  number of valid entries.
- err_o  out  1  sticky protocol-violation flag.

## Operation
- Per entry state: valid, rdy[1:0], tag[1:0].
- Dispatch (lane d, disp_valid_i[d]): entry disp_idx_i[d] gets valid=1, tags loaded; rdy[s] = disp_rdy_i[d][s] OR any wk_valid_i[w] with wk_tag_i[w]==disp_tag_i[d][s] in the same cycle (dispatch-wakeup bypass).
- Wakeup: for every valid, non-dispatching entry, rdy[s] set when any valid wakeup port matches tag[s]. Ready bits never clear except by dispatch overwrite.
- Grant: grant_i[i] clears valid[i] at the edge. Ready bits and tags left stale.
- Priority per entry: reset > flush > dispatch > grant > wakeup.
- Violations (set err_o, cleared only by reset): two lanes dispatching the same index in one cycle (lowest lane wins); dispatch to an entry valid and not granted this cycle (overwrites); grant_i[i] with req_o[i]==0 (ignored, entry unchanged).
- count_o: registered; next = count + dispatches to non-valid-or-granted entries − grants of valid entries; flush/reset to 0. Never exceeds IQ_SIZE.
- Wakeup for a tag absent from the array: no effect.

## Timing
- Reset: valid, rdy, count_o, err_o all 0; req_o=0, valid_o=0 from the cycle after reset is sampled high.
- req_o, valid_o: combinational from registered state only; no input-to-output combinational path.
- Dispatch in cycle t → valid_o high in t+1; req_o high in t+1 if both sources ready (including same-cycle wakeup).
- Wakeup in t → req_o high in t+1 (single-cycle wakeup-select loop with select tree in t+1).
- Grant in t → req_o and valid_o low in t+1; entry reallocatable by dispatch in t+1.
- Grant and dispatch to the same index in t: dispatch wins, entry valid in t+1 with new operands, no err_o.
- Flush in t: all outputs 0 in t+1; concurrent dispatch/wakeup/grant ignored.

## Structure
- Shared issue package: TAG_BITS, IQ_SIZE defaults, typedef of the entry record (valid, rdy[2], tag[2]), typedef for dispatch-lane payload.
- One sub-module: wakeup_tag_match — compares one TAG_BITS tag against all WAKEUP_WIDTH ports, outputs hit; instantiated per entry per source and per dispatch lane per source.

## Test plan
- Reset then dispatch idx 5, tags (10,11), rdy (1,1) → req_o[5]=1 next cycle, count_o=1.
- Dispatch idx 3 tags (20,21) rdy (0,0); wakeup 20 cycle t+2, 21 cycle t+4 → req_o[3] low until t+5, high from t+5.
- Dispatch idx 7 tag0=30 rdy0=0, rdy1=1 with wk_tag 30 same cycle → req_o[7]=1 next cycle (bypass).
- Entry 5 requesting, grant_i[5]=1 and dispatch to idx 5 same cycle → valid_o[5] stays 1, new tags, count_o unchanged, err_o=0.
- Fill all 32 entries ready, flush_i=1 → req_o=0, valid_o=0, count_o=0 next cycle.
- Two lanes dispatch idx 9 same cycle → lane 0 payload kept, err_o=1 and sticky until reset.
